// File: rtl/bus_arbiter_2m_if.sv
// Bus bundle shared by the two masters, the two slaves and the arbiter.
// The slave modport is the arbiter's view; the master modport is the
// environment's view (masters plus slave read-data sources).
interface bus_arbiter_2m_if;
  logic        M0_req;
  logic        M0_wr;
  logic [7:0]  M0_address;
  logic [31:0] M0_dout;
  logic        M0_grant;
  logic [31:0] M0_din;

  logic        M1_req;
  logic        M1_wr;
  logic [7:0]  M1_address;
  logic [31:0] M1_dout;
  logic        M1_grant;
  logic [31:0] M1_din;

  logic        S0_sel;
  logic        S1_sel;
  logic        S_wr;
  logic [7:0]  S_address;
  logic [31:0] S_din;
  logic [31:0] S0_dout;
  logic [31:0] S1_dout;

  logic        dec_err;

  modport slave (
    input  M0_req, M0_wr, M0_address, M0_dout,
    input  M1_req, M1_wr, M1_address, M1_dout,
    input  S0_dout, S1_dout,
    output M0_grant, M0_din, M1_grant, M1_din,
    output S0_sel, S1_sel, S_wr, S_address, S_din,
    output dec_err
  );

  modport master (
    output M0_req, M0_wr, M0_address, M0_dout,
    output M1_req, M1_wr, M1_address, M1_dout,
    output S0_dout, S1_dout,
    input  M0_grant, M0_din, M1_grant, M1_din,
    input  S0_sel, S1_sel, S_wr, S_address, S_din,
    input  dec_err
  );
endinterface

// File: rtl/bus_arbiter_2m.sv
// Two-master / two-slave bus controller. Round-robin arbitration with
// state-decoded grants; the owner keeps the bus until it drops req.
// The owner's address is decoded into slave selects, and read data comes
// back one cycle later, steered by a registered copy of the selects and
// broadcast to both masters so a handover never loses a pending read.
module bus_arbiter_2m #(
  parameter logic [7:0] S0_BASE = 8'h00,
  parameter int         S0_AW   = 5,
  parameter logic [7:0] S1_BASE = 8'h20,
  parameter int         S1_AW   = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  bus_arbiter_2m_if.slave       bus
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] GRANT0 = 2'd1;
  localparam logic [1:0] GRANT1 = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;
  logic [1:0]  rd_sel_q, rd_sel_d;
  logic        dec_err_q, dec_err_d;

  logic        granted;
  logic        own_wr;
  logic [7:0]  own_addr;
  logic [31:0] own_dout;
  logic        hit0, hit1;
  logic        s0_sel, s1_sel;
  logic [31:0] rd_data;

  // Next owner: hold while the owner requests, hand over directly, and break ties against last.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (bus.M0_req && bus.M1_req) begin
          state_d = last_q ? GRANT0 : GRANT1;
        end else if (bus.M0_req) begin
          state_d = GRANT0;
        end else if (bus.M1_req) begin
          state_d = GRANT1;
        end else begin
          state_d = IDLE;
        end
      end
      GRANT0: begin
        if (bus.M0_req)      state_d = GRANT0;
        else if (bus.M1_req) state_d = GRANT1;
        else                 state_d = IDLE;
      end
      GRANT1: begin
        if (bus.M1_req)      state_d = GRANT1;
        else if (bus.M0_req) state_d = GRANT0;
        else                 state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d == GRANT0 && state_q != GRANT0) last_d = 1'b0;
    if (state_d == GRANT1 && state_q != GRANT1) last_d = 1'b1;
  end

  // Address phase: pass the owner's signals through, everything zero when nobody owns the bus.
  always_comb begin
    granted  = 1'b0;
    own_wr   = 1'b0;
    own_addr = 8'h00;
    own_dout = 32'h0;
    case (state_q)
      GRANT0: begin
        granted  = 1'b1;
        own_wr   = bus.M0_wr;
        own_addr = bus.M0_address;
        own_dout = bus.M0_dout;
      end
      GRANT1: begin
        granted  = 1'b1;
        own_wr   = bus.M1_wr;
        own_addr = bus.M1_address;
        own_dout = bus.M1_dout;
      end
      default: ;
    endcase
  end

  // Window decode; slave 0 wins any overlap, unmapped accesses select nothing and flag dec_err.
  always_comb begin
    hit0      = (own_addr >> S0_AW) == (S0_BASE >> S0_AW);
    hit1      = (own_addr >> S1_AW) == (S1_BASE >> S1_AW);
    s0_sel    = granted & hit0;
    s1_sel    = granted & hit1 & ~hit0;
    rd_sel_d  = {s1_sel, s0_sel};
    dec_err_d = dec_err_q | (granted & ~hit0 & ~hit1);
  end

  // Read-data steering from the selects registered in the address cycle.
  always_comb begin
    case (rd_sel_q)
      2'b01:   rd_data = bus.S0_dout;
      2'b10:   rd_data = bus.S1_dout;
      default: rd_data = 32'h0;
    endcase
  end

  // Arbitration, read-steering and sticky error state, all cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      rd_sel_q  <= 2'b00;
      dec_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      rd_sel_q  <= rd_sel_d;
      dec_err_q <= dec_err_d;
    end
  end

  assign bus.M0_grant  = (state_q == GRANT0);
  assign bus.M1_grant  = (state_q == GRANT1);
  assign bus.S0_sel    = s0_sel;
  assign bus.S1_sel    = s1_sel;
  assign bus.S_wr      = own_wr & (s0_sel | s1_sel);
  assign bus.S_address = own_addr;
  assign bus.S_din     = own_dout;
  assign bus.M0_din    = rd_data;
  assign bus.M1_din    = rd_data;
  assign bus.dec_err   = dec_err_q;

endmodule

// File: doc/bus_arbiter_2m.md
Name: bus_arbiter_2m

Overview:
- Two-master, two-slave bus controller that lets the host/testbench master (M0) and the DMA master (M1) share one 8-bit-address, 32-bit-data bus.
- Round-robin arbitration with registered grants; a granted master holds the bus until it drops its request.
- Decodes the address to drive slave selects: S0 is the memory, S1 is the DMA slave register file.
- Returns read data one cycle after the address phase, routed by a registered slave select.

Parameters:
- S0_BASE, 8'h00, base address of slave 0 (memory).
- S0_AW, 5, log2 of the slave 0 window size (32 words).
- S1_BASE, 8'h20, base address of slave 1 (DMA registers).
- S1_AW, 3, log2 of the slave 1 window size (8 words).

Ports:
- clk  in  1  clock
- reset_n  in  1  reset; asynchronous, active-low
- M0_req  in  1  master 0 bus request
- M0_wr  in  1  master 0 write strobe
- M0_address  in  8  master 0 address
- M0_dout  in  32  master 0 write data
- M0_grant  out  1  master 0 owns the bus
- M0_din  out  32  read data to master 0
- M1_req, M1_wr, M1_address, M1_dout, M1_grant, M1_din  same as M0, for master 1 (DMA)
- S0_sel  out  1  slave 0 chip select
- S1_sel  out  1  slave 1 chip select
- S_wr  out  1  slave write strobe
- S_address  out  8  slave address
- S_din  out  32  slave write data
- S0_dout  in  32  slave 0 read data
- S1_dout  in  32  slave 1 read data
- dec_err  out  1  sticky: granted access hit an unmapped address

Behaviour:
- FSM states: IDLE, GRANT0, GRANT1. State register and `last` pointer reset asynchronously.
- Reset values:
  - state = IDLE, last = 1 (so M0 wins the first tie), rd_sel_q = none, dec_err = 0.
  - All outputs are 0.
- Grants are state-decoded: M0_grant = (state == GRANT0), M1_grant = (state == GRANT1). Grant is visible one cycle after req rises.
- IDLE transitions:
  - Only M0_req → GRANT0.
  - Only M1_req → GRANT1.
  - Both → grant the master ≠ last.
  - None → stay IDLE.
- GRANT0 transitions:
  - M0_req = 1 → stay (no preemption).
  - M0_req = 0 and M1_req = 1 → GRANT1 directly (zero idle cycles).
  - Otherwise → IDLE.
- GRANT1 transitions: symmetric to GRANT0.
- `last` updates to the owner on each entry into GRANT0 or GRANT1.
- Address phase (combinational from the granted master):
  - S_address, S_wr, S_din come from the owner.
  - In IDLE, S_address, S_wr and S_din are 0.
- Decode:
  - hit0 = (addr >> S0_AW) == (S0_BASE >> S0_AW).
  - hit1 uses S1_BASE and S1_AW in the same way.
  - S0_sel = granted & hit0; S1_sel = granted & hit1 & ~hit0 (S0 wins any overlap).
- Unmapped address while granted:
  - No select is asserted and the write is dropped.
  - dec_err sets and stays set until reset.
- Read data:
  - rd_sel_q <= {S1_sel, S0_sel} every cycle.
  - M0_din = M1_din = S0_dout if rd_sel_q == 01, S1_dout if rd_sel_q == 10, else 0.
  - Data is broadcast to both masters, so data for the previous owner is still returned correctly across a handover.
- Writes complete in the address cycle: the slave samples S_wr at the next clk edge.
- An ungranted master's wr/address/dout are ignored entirely.
- Reset mid-transfer: the bus is released immediately and asynchronously; selects and grants drop without waiting for clk.
- The same master re-asserting req after a one-cycle low, with the other master idle, is granted again (round-robin only matters on a tie).

Test Plan:
- Reset then M0_req = 1 alone → M0_grant = 1 at the next edge. M0 writes 32'hDEADBEEF to 8'h04 → S0_sel = 1, S_wr = 1, S_address = 8'h04. Next cycle a read of 8'h04 → M0_din = S0_dout one cycle later.
- Both requests rise in the same cycle from reset → M0 is granted first. M0 drops → M1_grant = 1 on the next edge with no IDLE gap. Both rise again later → M1 is not favoured; M0 wins because last = 1 after M1.
- M1 holds req for 20 cycles while M0_req = 1 → M0_grant stays 0 throughout; M0 is granted the cycle after M1_req falls.
- Granted write to 8'h22 → S1_sel = 1, S0_sel = 0. Access to 8'h80 → no select, write dropped, read data 0, dec_err = 1 and stays 1 through later valid accesses.
- Handover: M0 issues a read of 8'h10 in its last granted cycle, then M1 is granted → the S0_dout read result appears on M0_din the following cycle.
- reset_n asserted low mid-burst while GRANT1 → M1_grant, S0_sel, S1_sel, S_wr and dec_err are 0 immediately. After release, state = IDLE.
